lcd_timing_sink: RTL
====================

LCD_TIMING_SINK -- requirements
Module: lcd_timing_sink

Interface
REQ-001 Parameter H_ACTIVE, default 480, visible pixels per line.
REQ-002 Parameter H_SYNC / H_BP / H_FP, defaults 41 / 2 / 2, hsync, back porch and front porch widths in clocks.
REQ-003 Parameter V_ACTIVE, default 272, visible lines per frame.
REQ-004 Parameter V_SYNC / V_BP / V_FP, defaults 10 / 2 / 2, vsync, back porch and front porch widths in lines.
REQ-005 Parameter FIFO_DEPTH, default 16 (power of two), pixel buffer entries; PRIME, default 8, fill level that starts a frame.
REQ-006 clk  in  1  sole clock, all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 in_rgb  in  16  RGB565 pixel from upstream scaler ([15:11] R, [10:5] G, [4:0] B).
REQ-009 in_valid  in  1  in_rgb valid this cycle (upstream write_en).
REQ-010 in_stop  in  1  level; upstream has issued its last pixel.
REQ-011 in_ready  out  1  FIFO not full.
REQ-012 lcd_r / lcd_g / lcd_b  out  5 / 6 / 5  panel colour.
REQ-013 lcd_hsync / lcd_vsync  out  1  active-low syncs.
REQ-014 lcd_de  out  1  data enable, high on visible pixels.
REQ-015 frame_done  out  1  one-cycle pulse at end of final frame.
REQ-016 underflow / overflow  out  1  sticky error flags.

Function
REQ-017 The FIFO SHALL write when in_valid=1 and not full; in_valid=1 while full SHALL drop the pixel and set overflow.
REQ-018 Simultaneous write and read on a full or empty FIFO SHALL both succeed; the level is unchanged.
REQ-019 FSM states: IDLE, RUN, FLUSH.
REQ-020 IDLE: counters at 0, all syncs high, de=0, colour 0; go to RUN when level>=PRIME or (in_stop=1 and level>0).
REQ-021 RUN: h_cnt counts 0..H_TOTAL-1 (H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP) and wraps; v_cnt increments on h wrap and wraps at V_TOTAL (defined likewise).
REQ-022 hsync SHALL be low for h_cnt<H_SYNC; vsync low for v_cnt<V_SYNC.
REQ-023 Visible region: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
REQ-024 In the visible region the FIFO SHALL pop one pixel per clock; all lcd_* outputs are registered and appear exactly 1 clock after the counter value that produced them.
REQ-025 A visible-region pop with the FIFO empty SHALL output colour 0x0000 with de=1 and set underflow.
REQ-026 At the v_cnt/h_cnt wrap: if in_stop=1 and FIFO empty, go to FLUSH; otherwise stay in RUN and start the next frame.
REQ-027 FLUSH: for one clock drive idle outputs and pulse frame_done=1, then go to IDLE.
REQ-028 in_stop deasserting mid-frame SHALL have no effect on the current frame.
REQ-029 Counter and level widths SHALL be $clog2 of their maxima; there is no arithmetic overflow.

Reset
REQ-030 rst=1 SHALL clear the FIFO pointers and level, enter IDLE, zero counters, and drive in_ready=1, hsync=vsync=1, de=0, colour=0, frame_done=0, underflow=overflow=0.
REQ-031 rst mid-frame SHALL abort on the next edge; a pixel presented in the same cycle as rst is discarded.

Structure
REQ-032 A shared package SHALL hold the RGB565 field offsets, the default timing constants and the FSM state encoding.
REQ-033 The FIFO SHALL be a sub-module, pixel_fifo (sync, registered read, full/empty/level).

Verification
REQ-034 Reset, then 8 valid pixels: FSM moves IDLE->RUN; the first de=1 occurs on clock 43+1 after RUN entry with colour = pixel 0.
REQ-035 Stream 480x272 pixels of 0xF800 at one per clock with in_stop set after the last: lcd_r=31 on all 130560 de cycles, one frame_done, no flags.
REQ-036 Push 20 pixels with no pops: in_ready=0 after 16; overflow=1; the FIFO holds the first 16.
REQ-037 Stall input after PRIME pixels: the 9th visible pixel is 0x0000 with de=1; underflow=1 and stays set.
REQ-038 Assert rst at h_cnt=200, v_cnt=50: the next clock shows all reset values and the FSM in IDLE.

Source files
------------

// File: rtl/lcd_timing_sink_pkg.sv
// Shared definitions for the LCD timing sink: RGB565 field layout,
// default panel timing and the controller state encoding.
package lcd_timing_sink_pkg;

    localparam int PIX_W = 16;

    // RGB565 field positions inside a pixel word
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Default 480x272 panel timing (clocks per line / lines per frame)
    localparam int DEF_H_ACTIVE   = 480;
    localparam int DEF_H_SYNC     = 41;
    localparam int DEF_H_BP       = 2;
    localparam int DEF_H_FP       = 2;
    localparam int DEF_V_ACTIVE   = 272;
    localparam int DEF_V_SYNC     = 10;
    localparam int DEF_V_BP       = 2;
    localparam int DEF_V_FP       = 2;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_PRIME      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } lcd_state_e;

    // True when lo <= val < hi
    function automatic logic in_span(input int val, input int lo, input int hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/lcd_timing_sink_pixel_fifo.sv
// Synchronous pixel FIFO with registered read port. The read register
// holds the popped word for exactly one cycle and zero otherwise, so it
// can drive the panel colour directly. A write and a read in the same
// cycle both complete even when the FIFO is full or empty.
module pixel_fifo
    import lcd_timing_sink_pkg::*;
#(
    parameter int WIDTH = PIX_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, empty_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             do_wr_s, do_rd_s;

    // Accept/pop qualification and next fill level
    always_comb begin
        do_wr_s = wr_en_i && (!full_q || rd_en_i);
        do_rd_s = rd_en_i && (!empty_q || wr_en_i);
        level_d = level_q;
        if (do_wr_s && !do_rd_s) begin
            level_d = level_q + LVL_ONE;
        end else if (do_rd_s && !do_wr_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
    end

    // Storage array; pointers are reset instead, so no data reset needed
    always_ff @(posedge clk_i) begin
        if (do_wr_s && !rst_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers, level, flags and the read register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                // on an empty FIFO the word being written is forwarded
                rd_data_q <= empty_q ? wr_data_i : mem_q[rd_ptr_q];
            end else begin
                rd_data_q <= '0;
            end
            level_q <= level_d;
            full_q  <= (level_d == LVL_MAX);
            empty_q <= (level_d == '0);
        end
    end

    assign rd_data_o = rd_data_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign level_o   = level_q;

endmodule

// File: rtl/lcd_timing_sink.sv
// LCD timing generator fed by a pixel FIFO. Waits for the buffer to prime,
// then scans frames, popping one pixel per visible clock, and returns to
// idle at the end of a frame once upstream has stopped and drained.
module lcd_timing_sink
    import lcd_timing_sink_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int H_FP       = DEF_H_FP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int V_FP       = DEF_V_FP,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int PRIME      = DEF_PRIME
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] in_rgb,
    input  logic             in_valid,
    input  logic             in_stop,
    output logic             in_ready,
    output logic [4:0]       lcd_r,
    output logic [5:0]       lcd_g,
    output logic [4:0]       lcd_b,
    output logic             lcd_hsync,
    output logic             lcd_vsync,
    output logic             lcd_de,
    output logic             frame_done,
    output logic             underflow,
    output logic             overflow
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int LW      = $clog2(FIFO_DEPTH + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ONE      = HW'(1);
    localparam logic [VW-1:0] V_ONE      = VW'(1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [LW-1:0] PRIME_LVL  = LW'(PRIME);

    lcd_state_e       state_q, state_d;
    logic [HW-1:0]    h_cnt_q, h_cnt_d;
    logic [VW-1:0]    v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic             frame_done_q, frame_done_d;
    logic             underflow_q, underflow_d, overflow_q, overflow_d;
    logic             pop_s, visible_s;
    logic             full_s, empty_s;
    logic [LW-1:0]    level_s;
    logic [PIX_W-1:0] rd_data_s;

    pixel_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (in_valid),
        .wr_data_i (in_rgb),
        .rd_en_i   (pop_s),
        .rd_data_o (rd_data_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .level_o   (level_s)
    );

    // Frame sequencing, scan counters and next values of the panel outputs
    always_comb begin
        state_d      = state_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        hsync_d      = 1'b1;
        vsync_d      = 1'b1;
        de_d         = 1'b0;
        frame_done_d = 1'b0;
        pop_s        = 1'b0;
        visible_s    = in_span(int'(h_cnt_q), H_SYNC + H_BP, H_SYNC + H_BP + H_ACTIVE)
                    && in_span(int'(v_cnt_q), V_SYNC + V_BP, V_SYNC + V_BP + V_ACTIVE);
        case (state_q)
            ST_IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if ((level_s >= PRIME_LVL) || (in_stop && !empty_s)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                hsync_d = (h_cnt_q >= H_SYNC_END);
                vsync_d = (v_cnt_q >= V_SYNC_END);
                de_d    = visible_s;
                pop_s   = visible_s;
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == V_LAST) begin
                        v_cnt_d = '0;
                        // stop is only honoured at a frame boundary
                        if (in_stop && empty_s) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + V_ONE;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + H_ONE;
                end
            end
            ST_FLUSH: begin
                h_cnt_d      = '0;
                v_cnt_d      = '0;
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        underflow_d = underflow_q | (pop_s && empty_s && !in_valid);
        overflow_d  = overflow_q  | (in_valid && full_s && !pop_s);
    end

    // State, counters and registered panel outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            de_q         <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            de_q         <= de_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
        end
    end

    // Colour comes straight from the FIFO read register, which is zero
    // whenever no pixel was popped (blanking or underflow).
    assign lcd_r      = rd_data_s[R_MSB:R_LSB];
    assign lcd_g      = rd_data_s[G_MSB:G_LSB];
    assign lcd_b      = rd_data_s[B_MSB:B_LSB];
    assign lcd_hsync  = hsync_q;
    assign lcd_vsync  = vsync_q;
    assign lcd_de     = de_q;
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;
    assign overflow   = overflow_q;
    assign in_ready   = !full_s;

endmodule
